// File: rtl/memwb_writeback.sv
// MEM/WB pipeline register with load extraction and register-file writeback select.
// Optional retirement counter enabled by defining WB_RETIRE_CNT_EN.
module memwb_writeback #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          mem_valid,
  input  logic          mem_regwrite,
  input  logic          mem_memtoreg,
  input  logic [AW-1:0] mem_waddr,
  input  logic [DW-1:0] mem_alu_result,
  input  logic [DW-1:0] mem_rdata,
  input  logic [1:0]    mem_ld_size,
  input  logic          mem_ld_unsigned,
  output logic          wen,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] win,
  output logic          fwd_valid,
  output logic [AW-1:0] fwd_waddr,
  output logic [DW-1:0] fwd_data,
  output logic          wb_misalign
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]   retire_cnt
`endif
);

  typedef struct packed {
    logic          valid;
    logic          regwrite;
    logic          memtoreg;
    logic [AW-1:0] waddr;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] rdata;
    logic [1:0]    ld_size;
    logic          ld_unsigned;
  } wb_reg_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  wb_reg_t wb_q, wb_d, mem_in;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mem_in.valid       = mem_valid;
    mem_in.regwrite    = mem_regwrite;
    mem_in.memtoreg    = mem_memtoreg;
    mem_in.waddr       = mem_waddr;
    mem_in.alu_result  = mem_alu_result;
    mem_in.rdata       = mem_rdata;
    mem_in.ld_size     = mem_ld_size;
    mem_in.ld_unsigned = mem_ld_unsigned;

    wb_d = wb_q;
    if (flush) begin
      wb_d       = mem_in;
      wb_d.valid = 1'b0;
    end else if (!stall) begin
      wb_d = mem_in;
    end
  end

  // NOTE: the payload fields are reset too, so every output reads zero after reset, not just wen.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      wb_q <= wb_d;
    end
  end

  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [DW-1:0] load_data;
  logic          misal;
  logic          wen_int;
  logic [DW-1:0] win_int;

  // Big-endian lanes: offset 0 is the most significant byte.
  always_comb begin
    case (wb_q.alu_result[1:0])
      2'd0:    byte_sel = wb_q.rdata[31:24];
      2'd1:    byte_sel = wb_q.rdata[23:16];
      2'd2:    byte_sel = wb_q.rdata[15:8];
      default: byte_sel = wb_q.rdata[7:0];
    endcase
    half_sel = wb_q.alu_result[1] ? wb_q.rdata[15:0] : wb_q.rdata[31:16];

    case (wb_q.ld_size)
      SZ_HALF: load_data = {{(DW-16){~wb_q.ld_unsigned & half_sel[15]}}, half_sel};
      SZ_BYTE: load_data = {{(DW-8){~wb_q.ld_unsigned & byte_sel[7]}}, byte_sel};
      default: load_data = wb_q.rdata;
    endcase

    misal = 1'b0;
    if (wb_q.valid && wb_q.memtoreg) begin
      case (wb_q.ld_size)
        SZ_WORD: misal = (wb_q.alu_result[1:0] != 2'b00);
        SZ_HALF: misal = wb_q.alu_result[0];
        SZ_BYTE: misal = 1'b0;
        default: misal = 1'b1;
      endcase
    end
  end

  assign win_int = wb_q.memtoreg ? load_data : wb_q.alu_result;
  assign wen_int = wb_q.valid & wb_q.regwrite & ~misal & (wb_q.waddr != '0);

  assign wen         = wen_int;
  assign waddr       = wb_q.waddr;
  assign win         = win_int;
  assign fwd_valid   = wen_int;
  assign fwd_waddr   = wb_q.waddr;
  assign fwd_data    = win_int;
  assign wb_misalign = misal;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic        retire_evt;

  // An instruction retires on the edge it leaves WB, so a stalled one counts once.
  assign retire_evt   = wb_q.valid & ~misal & ~stall;
  assign retire_cnt_d = retire_evt ? retire_cnt_q + 32'd1 : retire_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule
